// File: rtl/interboard_pkg.sv
// Shared definitions for the inter-board Request/Ack link (receiver and transmitter).
// Message types, beat layout and receiver FSM states.
package interboard_pkg;

    localparam logic [2:0] MSG_RST   = 3'd0;
    localparam logic [2:0] MSG_START = 3'd1;
    localparam logic [2:0] MSG_NUM   = 3'd2;
    localparam logic [2:0] MSG_WIN   = 3'd3;
    localparam logic [2:0] MSG_READY = 3'd4;

    localparam int unsigned BEAT_MARK_BIT = 5;

    typedef enum logic [2:0] {
        StWaitLow,
        StIdle,
        StAck0,
        StWait1,
        StAck1,
        StAckDrop
    } rx_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Deliberately unreset: clearing it would fake a low request and let a held beat be re-acked.
module sync_ff #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_d, sync_q;

    always_comb begin
        sync_d[0] = d_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        sync_q <= sync_d;
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/interboard_receiver.sv
// Receive side of the 4-phase Request/Ack inter-board link: acks each 6-bit beat and
// reassembles two-beat frames into {msg_type, number}, delivered as a one-cycle pulse.
module interboard_receiver
    import interboard_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Request_in,
    input  logic [5:0] inter_data_in,
    output logic       Ack_out,
    output logic       interboard_en,
    output logic [2:0] interboard_msg_type,
    output logic [4:0] interboard_number,
    output logic       interboard_rst,
    output logic       frame_err
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    rx_state_e       state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic [2:0]      type_d, type_q;
    logic [2:0]      msg_type_d, msg_type_q;
    logic [4:0]      number_d, number_q;
    logic            ack_d, ack_q;
    logic            en_d, en_q;
    logic            irst_d, irst_q;
    logic            err_d, err_q;

    logic req_s;
    logic marker;
    logic timeout;

    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk_i(clk),
        .d_i  (Request_in),
        .q_o  (req_s)
    );

    assign marker  = inter_data_in[BEAT_MARK_BIT];
    assign timeout = (cnt_q == CntLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StWaitLow;
            cnt_q      <= '0;
            type_q     <= '0;
            msg_type_q <= '0;
            number_q   <= '0;
            ack_q      <= 1'b0;
            en_q       <= 1'b0;
            irst_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            type_q     <= type_d;
            msg_type_q <= msg_type_d;
            number_q   <= number_d;
            ack_q      <= ack_d;
            en_q       <= en_d;
            irst_q     <= irst_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitLow: if (!req_s) state_d = StIdle;
            StIdle:    if (req_s) state_d = marker ? StAck0 : StAckDrop;
            StAck0:    if (!req_s) state_d = StWait1;
            StWait1: begin
                if (req_s)        state_d = marker ? StAck0 : StAck1;
                else if (timeout) state_d = StIdle;
            end
            StAck1:    if (!req_s) state_d = StIdle;
            StAckDrop: if (!req_s) state_d = StIdle;
            default:   state_d = StWaitLow;
        endcase
    end

    always_comb begin
        ack_d  = (state_d == StAck0) || (state_d == StAck1) || (state_d == StAckDrop);
        en_d   = (state_q == StWait1) && (state_d == StAck1);
        irst_d = en_d && (type_q == MSG_RST);
        err_d  = ((state_q == StIdle) && req_s && !marker) ||
                 ((state_q == StWait1) && (req_s ? marker : timeout));

        // A new beat 0, from idle or restarting mid-frame, replaces the pending type.
        type_d = type_q;
        if ((state_d == StAck0) && (state_q != StAck0)) begin
            type_d = inter_data_in[2:0];
        end else if ((state_q == StWait1) && (state_d == StIdle)) begin
            type_d = '0;
        end

        msg_type_d = msg_type_q;
        number_d   = number_q;
        if (en_d) begin
            msg_type_d = type_q;
            number_d   = inter_data_in[4:0];
        end

        cnt_d = '0;
        if (state_q == StWait1) begin
            cnt_d = timeout ? cnt_q : cnt_q + 1'b1;
        end
    end

    assign Ack_out             = ack_q;
    assign interboard_en       = en_q;
    assign interboard_rst      = irst_q;
    assign frame_err           = err_q;
    assign interboard_msg_type = msg_type_q;
    assign interboard_number   = number_q;

endmodule
